// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer control path: state encoding and
// expiry tally width, used by the RTL and by the bench for state checks.
package interval_timer_ctrl_pkg;

    localparam int unsigned EXP_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOAD   = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_EXPIRE = 2'b11;

    typedef logic [EXP_W-1:0] exp_cnt_t;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between the timer FSM and its environment
// (request strobes in, counter strobes and status out).
interface interval_timer_ctrl_if;
    import interval_timer_ctrl_pkg::*;

    logic     start;
    logic     stop;
    logic     pause;
    logic     periodic;
    logic     tcount;
    logic     ld;
    logic     cnt;
    logic     done;
    logic     busy;
    exp_cnt_t expire_cnt;

    modport master (
        output start, stop, pause, periodic, tcount,
        input  ld, cnt, done, busy, expire_cnt
    );

    modport slave (
        input  start, stop, pause, periodic, tcount,
        output ld, cnt, done, busy, expire_cnt
    );

endinterface

// File: rtl/interval_timer_ctrl_incrementor_4b.sv
// Combinational +1 modulo 16; counterpart of the 4-bit decrementor.
module incrementor_4b (
    input  logic [3:0] a,
    output logic [3:0] y
);

    assign y = a + 4'd1;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Control FSM for the 4-bit down-counter: sequences ld/cnt, turns tcount
// into one-shot or periodic expiries, and tallies expiries modulo 16.
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    interval_timer_ctrl_if.slave tif
);

    logic [1:0] state_q, state_d;
    exp_cnt_t   expire_cnt_q, expire_cnt_d, expire_cnt_inc;
    logic       clr, exp_ld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tif.start && !tif.stop) state_d = ST_LOAD;
            ST_LOAD:   state_d = tif.stop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (tif.stop)        state_d = ST_IDLE;
                else if (tif.tcount) state_d = ST_EXPIRE;
            end
            ST_EXPIRE: begin
                if (tif.stop)          state_d = ST_IDLE;
                else if (tif.periodic) state_d = ST_LOAD;
                else                   state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    incrementor_4b u_inc (
        .a (expire_cnt_q),
        .y (expire_cnt_inc)
    );

    // Load register with a clear mux in front; EXPIRE always bumps the tally,
    // even when stop cuts the period short on the exit edge.
    always_comb begin
        clr          = (state_q == ST_IDLE) && tif.start && !tif.stop;
        exp_ld       = (state_q == ST_EXPIRE) || clr;
        expire_cnt_d = clr ? '0 : expire_cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         expire_cnt_q <= '0;
        else if (exp_ld) expire_cnt_q <= expire_cnt_d;
    end

    // cnt is gated by tcount so the counter never wraps past zero.
    assign tif.ld         = (state_q == ST_LOAD);
    assign tif.cnt        = (state_q == ST_RUN) && !tif.tcount && !tif.pause;
    assign tif.done       = (state_q == ST_EXPIRE);
    assign tif.busy       = (state_q != ST_IDLE);
    assign tif.expire_cnt = expire_cnt_q;

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Control-path FSM for the 4-bit down-counter datapath: sequences the counter's load and count-enable strobes, consumes its terminal-count flag, and turns it into one-shot or periodic timer expiries. It sits directly upstream of the down-counter's control inputs and downstream of its `tcount` output; the counter's 4-bit data input is driven from the period value elsewhere, not through this block. It also keeps a wrap-around tally of expiries for status readout.

## Interface
- No parameters; counter width is fixed at 4 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin timing; sampled in IDLE only.
- `stop`  in  1  abort; highest priority after `rst`.
- `pause`  in  1  hold the counter in RUN; no state change.
- `periodic`  in  1  1 = reload after expiry; 0 = one-shot.
- `tcount`  in  1  counter terminal count, combinational (count == 0).
- `ld`  out  1  counter load strobe.
- `cnt`  out  1  counter decrement enable.
- `done`  out  1  one-cycle expiry pulse.
- `busy`  out  1  high in every state except IDLE.
- `expire_cnt`  out  4  expiries since last start from IDLE.

## Operation
- States: IDLE, LOAD, RUN, EXPIRE.
- IDLE: `start`=1 and `stop`=0 -> LOAD; on that edge `expire_cnt` clears to 0. Otherwise stay.
- LOAD: `ld`=1 for exactly one cycle -> RUN. `stop`=1 -> IDLE, and `ld` is still high that cycle.
- RUN: `cnt` = ~`tcount` & ~`pause` (Mealy). `stop` -> IDLE. Else `tcount`=1 -> EXPIRE. Else stay.
- EXPIRE: `done`=1; `expire_cnt` increments on exit edge, modulo 16 (15 -> 0). Exit is `stop` -> IDLE (increment still applies), `periodic` -> LOAD, else IDLE.
- `ld` and `cnt` are never high together. `cnt` is never high while `tcount`=1, so the counter never wraps 0 -> 15.
- `periodic`, `pause` and `stop` are level-sampled each cycle. Changing `periodic` mid-RUN takes effect at the next EXPIRE.
- `start` outside IDLE is ignored.

## Timing
- Reset values (asynchronous): state IDLE; `ld`=0, `cnt`=0, `done`=0, `busy`=0, `expire_cnt`=0.
- `rst` mid-operation returns to IDLE immediately. Outputs drop in the same cycle, not at the next edge.
- `start` sampled at edge k gives LOAD during k+1. With period N loaded, RUN spans N+1 cycles (N decrement cycles plus one cycle with `tcount`=1). `done` is high in cycle k+N+3.
- Periodic spacing between `done` pulses: N+3 cycles.
- Period 0: RUN lasts one cycle, `cnt` stays 0, and EXPIRE follows directly.
- `pause` in RUN stretches RUN by one cycle per paused cycle.
- `stop` and `tcount` in the same RUN cycle: go to IDLE, with no `done` and no increment.
- `stop` and `start` together in IDLE: stay in IDLE, and `expire_cnt` is not cleared.
- All state and `expire_cnt` update on the rising edge. `ld`, `done` and `busy` are decoded from state only. `cnt` also depends on `tcount` and `pause`.

## Structure
- Shared include holds the state encoding localparams (2-bit: IDLE=00, LOAD=01, RUN=10, EXPIRE=11). The same include is used by the bench for state checks.
- One sub-module: `incrementor_4b`, a combinational +1 modulo 16 for `expire_cnt`. It is the dual of the team's decrementor.
- The register for `expire_cnt` reuses the team's existing 4-bit load register: load = (state==EXPIRE) | clear, with a clear mux in front.
- The FSM state register is a plain async-reset always block with a separate combinational next-state block.

## Test plan
- **One-shot, N=3:** pulse `start`. Required: LOAD for 1 cycle, `cnt` high 3 cycles, `done` high exactly once at k+6, return to IDLE, `expire_cnt`=1, `busy` low after.
- **Periodic, N=2:** run for 20 cycles. Required: `done` every 5 cycles, `expire_cnt` counts 1,2,3,4; `ld` high in every LOAD, never overlapping `cnt`.
- **Wrap:** periodic with N=0 for 17 expiries. Required: `done` every 3 cycles and `expire_cnt` reads 15 then 0 then 1.
- **Pause:** N=4, hold `pause` for 3 cycles mid-RUN. Required: `cnt` low during the pause and `done` delayed by exactly 3 cycles.
- **Stop collision:** assert `stop` in the RUN cycle where `tcount`=1. Required: next state IDLE, no `done`, `expire_cnt` unchanged.
- **Reset mid-RUN:** assert `rst` asynchronously mid-RUN. Required: outputs go to reset values before the next edge; `start` after release restarts cleanly with `expire_cnt`=0.
